// File: rtl/key_entry_ctrl.sv
// Purpose: builds a keypad code from 2-bit digits, checks it, and enforces the inter-digit timeout and lockout.
// Latency: digit captured 2 CLK edges after the first edge that samples KB_RECV high; the result is registered at that same edge.
// Backpressure: none; digits during lockout are dropped and KEY_VALID is a single-cycle pulse with no handshake.
module key_entry_ctrl #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0] CODE           = 8'b00_01_10_11,
  parameter int                    DIGIT_TIMEOUT  = 5000,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    LOCKOUT_CYCLES = 30000
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [1:0] KB_IN,
  input  logic       KB_RECV,
  input  logic       DISARM_SEL,
  output logic [1:0] KEY_STATUS,
  output logic       KEY_VALID,
  output logic       ENTRY_ACTIVE,
  output logic       LOCKED
);

  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TW_D = $clog2(DIGIT_TIMEOUT + 1);
  localparam int TW_L = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TW   = (TW_D > TW_L) ? TW_D : TW_L;

  localparam logic [CW-1:0] LAST_IDX = CW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
  localparam logic [TW-1:0] TO_LAST  = TW'(DIGIT_TIMEOUT - 1);
  localparam logic [TW-1:0] LO_LAST  = TW'(LOCKOUT_CYCLES - 1);

  localparam logic [1:0] KEY_OK    = 2'd0;
  localparam logic [1:0] KEY_OKNEG = 2'd1;
  localparam logic [1:0] KEY_ERROR = 2'd2;
  localparam logic [1:0] NO_KEY    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          kb_sync1, kb_sync2, kb_prev;
  logic          digit_evt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mism, mism_nxt;
  logic [FW-1:0] fail, fail_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic          vld_nxt;
  logic [1:0]    sts_nxt;

  logic [2*CODE_LEN-1:0] code_sh;
  logic [1:0]            exp_digit;
  logic                  accept, complete, mism_acc, lock_hit, to_exp, lo_exp;
  logic [FW-1:0]         fail_inc;

  // The digit expected at the current position sits in the top two bits once CODE is shifted by 2*cnt.
  assign code_sh   = CODE << {cnt, 1'b0};
  assign exp_digit = code_sh[2*CODE_LEN-1 -: 2];

  assign digit_evt = kb_sync2 & ~kb_prev;
  assign accept    = digit_evt && (state != ST_LOCKOUT);
  assign mism_acc  = mism | (KB_IN != exp_digit);
  assign complete  = accept && (cnt == LAST_IDX);
  assign fail_inc  = (fail == FAIL_MAX) ? fail : fail + FW'(1);
  assign lock_hit  = complete && mism_acc && (fail_inc == FAIL_MAX);
  // A digit arriving on the expiry cycle wins over the timeout.
  assign to_exp    = (state == ST_ENTRY) && (tmr == TO_LAST) && !digit_evt;
  assign lo_exp    = (state == ST_LOCKOUT) && (tmr == LO_LAST);

  // Synchronise the asynchronous strobe and keep its previous value for rising-edge detection.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      kb_sync1 <= 1'b0;
      kb_sync2 <= 1'b0;
      kb_prev  <= 1'b0;
    end else begin
      kb_sync1 <= KB_RECV;
      kb_sync2 <= kb_sync1;
      kb_prev  <= kb_sync2;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision: collect digits, finish or lock out, time out, and release the lockout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ENTRY: begin
        if (accept) begin
          if (complete) state_nxt = lock_hit ? ST_LOCKOUT : ST_IDLE;
          else          state_nxt = ST_ENTRY;
        end else if (to_exp) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOCKOUT: if (lo_exp) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and result next values; the result registers load NO_KEY whenever nothing completes.
  always_comb begin
    cnt_nxt  = cnt;
    mism_nxt = mism;
    fail_nxt = fail;
    tmr_nxt  = tmr;
    vld_nxt  = 1'b0;
    sts_nxt  = NO_KEY;
    case (state)
      ST_IDLE, ST_ENTRY: begin
        if (accept) begin
          tmr_nxt = '0;
          if (complete) begin
            cnt_nxt  = '0;
            mism_nxt = 1'b0;
            vld_nxt  = 1'b1;
            if (mism_acc) begin
              sts_nxt  = KEY_ERROR;
              fail_nxt = fail_inc;
            end else begin
              sts_nxt  = DISARM_SEL ? KEY_OKNEG : KEY_OK;
              fail_nxt = '0;
            end
          end else begin
            cnt_nxt  = cnt + CW'(1);
            mism_nxt = mism_acc;
          end
        end else if (state == ST_ENTRY) begin
          if (to_exp) begin
            cnt_nxt  = '0;
            mism_nxt = 1'b0;
            tmr_nxt  = '0;
          end else begin
            tmr_nxt = tmr + TW'(1);
          end
        end
      end
      ST_LOCKOUT: begin
        if (lo_exp) begin
          tmr_nxt  = '0;
          fail_nxt = '0;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end
      default: begin
        cnt_nxt  = '0;
        mism_nxt = 1'b0;
        tmr_nxt  = '0;
      end
    endcase
  end

  // Datapath and registered result outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt        <= '0;
      mism       <= 1'b0;
      fail       <= '0;
      tmr        <= '0;
      KEY_VALID  <= 1'b0;
      KEY_STATUS <= NO_KEY;
    end else begin
      cnt        <= cnt_nxt;
      mism       <= mism_nxt;
      fail       <= fail_nxt;
      tmr        <= tmr_nxt;
      KEY_VALID  <= vld_nxt;
      KEY_STATUS <= sts_nxt;
    end
  end

  assign ENTRY_ACTIVE = (state == ST_ENTRY);
  assign LOCKED       = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: random and scenario-driven digit streams checked every cycle against a timeline model.
// The model works in capture-edge times and digit queues: a code completes on its 4th held digit, entries expire 20 cycles after the last digit.
// Lockout spans 50 cycles from the lockout-triggering result; digits landing in that window, including its end edge, are dropped.
module tb_key_entry_ctrl;

  localparam int        TO   = 20;
  localparam int        LO   = 50;
  localparam logic [7:0] CODE_P = 8'b00_01_10_11;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic [1:0] KB_IN;
  logic       KB_RECV;
  logic       DISARM_SEL;
  logic [1:0] KEY_STATUS;
  logic       KEY_VALID;
  logic       ENTRY_ACTIVE;
  logic       LOCKED;

  key_entry_ctrl #(
    .CODE_LEN       (4),
    .CODE           (CODE_P),
    .DIGIT_TIMEOUT  (TO),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (LO)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .KB_IN        (KB_IN),
    .KB_RECV      (KB_RECV),
    .DISARM_SEL   (DISARM_SEL),
    .KEY_STATUS   (KEY_STATUS),
    .KEY_VALID    (KEY_VALID),
    .ENTRY_ACTIVE (ENTRY_ACTIVE),
    .LOCKED       (LOCKED)
  );

  always #5 CLK = ~CLK;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference timeline state.
  int         cap_e[$];
  logic [1:0] cap_d[$];
  logic [1:0] held[$];
  int         last_cap  = 0;
  int         lock_end  = 0;
  bit         m_locked  = 1'b0;
  int         fails     = 0;
  logic [7:0] code_v    = CODE_P;
  int         n_valid   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge and compare every output just after that edge.
  always @(posedge CLK) begin
    bit         have, ok, e_vld;
    logic [1:0] d, e_sts;
    cyc++;
    #1;
    if (!RST_n) begin
      cap_e.delete(); cap_d.delete(); held.delete();
      m_locked = 1'b0; fails = 0;
      chk("rst_vld",    32'(KEY_VALID),    32'd0);
      chk("rst_status", 32'(KEY_STATUS),   32'd3);
      chk("rst_entry",  32'(ENTRY_ACTIVE), 32'd0);
      chk("rst_locked", 32'(LOCKED),       32'd0);
    end else begin
      have  = 1'b0;
      d     = 2'd0;
      e_vld = 1'b0;
      e_sts = 2'd3;
      if (cap_e.size() > 0 && cap_e[0] == cyc) begin
        have = 1'b1;
        d    = cap_d.pop_front();
        void'(cap_e.pop_front());
      end
      if (m_locked) begin
        if (cyc == lock_end) begin
          m_locked = 1'b0;
          fails    = 0;
        end
      end else if (have) begin
        held.push_back(d);
        last_cap = cyc;
        if (held.size() == 4) begin
          ok = 1'b1;
          for (int i = 0; i < 4; i++)
            if (held[i] != code_v[7-2*i -: 2]) ok = 1'b0;
          e_vld = 1'b1;
          if (ok) begin
            e_sts = DISARM_SEL ? 2'd1 : 2'd0;
            fails = 0;
          end else begin
            e_sts = 2'd2;
            fails++;
            if (fails == 3) begin
              m_locked = 1'b1;
              lock_end = cyc + LO;
            end
          end
          held.delete();
        end
      end else if (held.size() > 0 && cyc - last_cap >= TO) begin
        held.delete();
      end
      if (e_vld) n_valid++;
      chk("key_valid",    32'(KEY_VALID),    32'(e_vld));
      chk("key_status",   32'(KEY_STATUS),   32'(e_sts));
      chk("entry_active", 32'(ENTRY_ACTIVE), 32'(held.size() > 0));
      chk("locked",       32'(LOCKED),       32'(m_locked));
    end
  end

  // One strobe: rises 2ns after an edge, so the next edge is the first to sample it and the capture is 3 edges on.
  task automatic send_digit(input logic [1:0] d, input logic dis, input int hi, input int lo);
    @(posedge CLK); #2;
    KB_IN      = d;
    DISARM_SEL = dis;
    KB_RECV    = 1'b1;
    cap_e.push_back(cyc + 3);
    cap_d.push_back(d);
    repeat (hi) @(posedge CLK);
    #2 KB_RECV = 1'b0;
    repeat (lo) @(posedge CLK);
  endtask

  task automatic send_code(input logic [7:0] c, input logic dis, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_digit(c[7-2*i -: 2], dis, 3, 3);
      repeat (gap) @(posedge CLK);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic pulse_reset(input int n);
    @(posedge CLK); #2;
    RST_n = 1'b0;
    #1;
    chk("arst_vld",    32'(KEY_VALID),    32'd0);
    chk("arst_status", 32'(KEY_STATUS),   32'd3);
    chk("arst_entry",  32'(ENTRY_ACTIVE), 32'd0);
    chk("arst_locked", 32'(LOCKED),       32'd0);
    repeat (n) @(posedge CLK);
    #2 RST_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int v0;
    RST_n      = 1'b0;
    KB_IN      = 2'd0;
    KB_RECV    = 1'b0;
    DISARM_SEL = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST_n = 1'b1;
    idle(3);

    // Correct code, then the disarm variant.
    send_code(8'b00_01_10_11, 1'b0, 0); idle(5);
    send_code(8'b00_01_10_11, 1'b1, 0); idle(5);
    // Wrong code followed by two more to reach lockout, then attempts while locked.
    send_code(8'b00_01_10_10, 1'b0, 0); idle(3);
    send_code(8'b11_01_10_11, 1'b0, 2); idle(3);
    send_code(8'b00_00_10_11, 1'b0, 0); idle(2);
    send_code(8'b00_01_10_11, 1'b0, 0);
    idle(60);
    send_code(8'b00_01_10_11, 1'b0, 0); idle(5);
    // A correct code in between clears the fail history.
    send_code(8'b01_01_01_01, 1'b0, 0);
    send_code(8'b10_01_10_11, 1'b0, 0);
    send_code(8'b00_01_10_11, 1'b1, 0);
    send_code(8'b00_01_10_00, 1'b0, 0);
    send_code(8'b00_11_10_11, 1'b0, 0); idle(5);
    send_code(8'b00_01_10_11, 1'b0, 0); idle(5);
    // Timeout discards a partial entry; a digit exactly 20 cycles after the last one still counts.
    send_digit(2'd0, 1'b0, 3, 3);
    send_digit(2'd1, 1'b0, 3, 3);
    idle(25);
    send_code(8'b00_01_10_11, 1'b0, 0); idle(5);
    send_code(8'b00_01_10_11, 1'b0, 13); idle(5);
    send_digit(2'd0, 1'b0, 3, 3); idle(14);
    send_digit(2'd1, 1'b0, 3, 3); idle(25);
    // Reset mid-entry drops held digits.
    send_digit(2'd0, 1'b0, 3, 3);
    send_digit(2'd1, 1'b0, 3, 3);
    pulse_reset(2);
    idle(2);
    send_code(8'b10_11_00_01, 1'b0, 0); idle(5);

    v0 = n_valid;
    // Randomised attempts: mixed correct/random codes, varied strobe widths and gaps straddling the timeout.
    for (int a = 0; a < 60; a++) begin
      bit         good;
      logic       dis;
      int         g;
      logic [1:0] dg;
      good = ($urandom_range(0, 9) < 4);
      dis  = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        dg = good ? 2'(i) : 2'($urandom_range(0, 3));
        send_digit(dg, dis, $urandom_range(3, 6), $urandom_range(3, 4));
        case ($urandom_range(0, 9))
          0:       g = 13;
          1:       g = 14;
          2:       g = $urandom_range(15, 30);
          default: g = $urandom_range(0, 4);
        endcase
        idle(g);
      end
      if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0)  idle($urandom_range(20, 60));
    end
    idle(60);
    if (n_valid == v0) chk("random_results_seen", 32'(n_valid - v0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
